// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source encoding for the fetch-stage PC unit.
package pc_pkg;

   localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;
   localparam int          PC_INC       = 4;

   // Winning next-PC source, listed in priority order.
   typedef enum logic [2:0] {
      SRC_EXC  = 3'd0,
      SRC_BR   = 3'd1,
      SRC_HOLD = 3'd2,
      SRC_RET  = 3'd3,
      SRC_CALL = 3'd4,
      SRC_JMP  = 3'd5,
      SRC_SEQ  = 3'd6
   } pc_src_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
module return_addr_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_pop;
   logic             do_push;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_W'(DEPTH));
   assign top     = mem[ptr];
   assign do_pop  = pop && !clear && !empty;
   assign do_push = push && !clear && !pop;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         ptr <= '0;
         cnt <= '0;
      end else if (clear) begin
         ptr <= '0;
         cnt <= '0;
      end else if (do_pop) begin
         ptr <= ptr - PTR_W'(1);
         cnt <= cnt - CNT_W'(1);
      end else if (do_push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) cnt <= cnt + CNT_W'(1);
      end
   end

   // NOTE: storage has no reset; the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[ptr + PTR_W'(1)] <= din;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised redirects, exception PC capture and a return-address stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
   parameter int                INC       = PC_INC,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              holdPC,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              exception,
   output logic [ADDR_W-1:0] outPC,
   output logic [ADDR_W-1:0] epc,
   output logic              ras_empty,
   output logic              ras_full
);

   pc_src_e           src;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W-1:0] ras_top;

   always_comb begin
      src     = SRC_SEQ;
      next_pc = outPC + ADDR_W'(INC);
      if (exception) begin
         src     = SRC_EXC;
         next_pc = EXC_VEC;
      end else if (branch_taken) begin
         src     = SRC_BR;
         next_pc = branch_target;
      end else if (holdPC) begin
         src     = SRC_HOLD;
         next_pc = outPC;
      end else if (ret) begin
         // An empty stack falls back to the decoded target instead of underflowing.
         src     = SRC_RET;
         next_pc = ras_empty ? jump_target : ras_top;
      end else if (call) begin
         src     = SRC_CALL;
         next_pc = jump_target;
      end else if (jump) begin
         src     = SRC_JMP;
         next_pc = jump_target;
      end
   end

   return_addr_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W)
   ) u_ras (
      .clk   (clk),
      .Reset (Reset),
      .push  (src == SRC_CALL),
      .pop   (src == SRC_RET),
      .clear (src == SRC_EXC),
      .din   (outPC),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         outPC <= RESET_VEC;
         epc   <= '0;
      end else begin
         outPC <= next_pc;
         if (src == SRC_EXC) epc <= outPC;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RVEC  = 32'h0000_0000;
   localparam logic [31:0] EVEC  = 32'h0000_0080;

   logic        clk;
   logic        Reset;
   logic        holdPC;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic        call;
   logic        ret;
   logic [31:0] jump_target;
   logic        exception;
   logic [31:0] outPC;
   logic [31:0] epc;
   logic        ras_empty;
   logic        ras_full;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: PC, EPC and the live return addresses (oldest first).
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic [31:0] m_ras[$];

   pc_unit #(
      .ADDR_W    (32),
      .RESET_VEC (RVEC),
      .EXC_VEC   (EVEC),
      .INC       (4),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .Reset         (Reset),
      .holdPC        (holdPC),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .jump_target   (jump_target),
      .exception     (exception),
      .outPC         (outPC),
      .epc           (epc),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      holdPC        = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      call          = 1'b0;
      ret           = 1'b0;
      jump_target   = 32'h0;
      exception     = 1'b0;
   endtask

   task automatic model_reset();
      m_pc  = RVEC;
      m_epc = 32'h0;
      m_ras.delete();
   endtask

   task automatic model_step();
      if (exception) begin
         m_epc = m_pc;
         m_pc  = EVEC;
         m_ras.delete();
      end else if (branch_taken) begin
         m_pc = branch_target;
      end else if (holdPC) begin
         m_pc = m_pc;
      end else if (ret) begin
         if (m_ras.size() > 0) m_pc = m_ras.pop_back();
         else                  m_pc = jump_target;
      end else if (call) begin
         m_ras.push_back(m_pc);
         if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         m_pc = jump_target;
      end else if (jump) begin
         m_pc = jump_target;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_pc"},    outPC,            m_pc);
      check({tag, "_epc"},   epc,              m_epc);
      check({tag, "_empty"}, 32'(ras_empty),   32'(m_ras.size() == 0));
      check({tag, "_full"},  32'(ras_full),    32'(m_ras.size() == DEPTH));
   endtask

   // Apply the current inputs across one rising edge and compare just after it.
   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
      idle_inputs();
   endtask

   // Assert Reset between edges, confirm it acts without a clock, hold it over one edge.
   task automatic async_reset(input string tag);
      #3 Reset = 1'b1;
      #1;
      check({tag, "_async_pc"}, outPC, RVEC);
      model_reset();
      check_model({tag, "_async"});
      @(posedge clk);
      #1;
      check_model({tag, "_held"});
      Reset = 1'b0;
   endtask

   task automatic branch_to(input logic [31:0] t);
      branch_taken  = 1'b1;
      branch_target = t;
      step("br_setup");
   endtask

   initial begin
      logic [31:0] r;
      idle_inputs();
      Reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_model("reset");
      Reset = 1'b0;

      // Sequential fetch after release, then a clockless reset mid-cycle.
      step("seq1"); check("seq1_exp", outPC, 32'h4);
      step("seq2"); check("seq2_exp", outPC, 32'h8);
      step("seq3"); check("seq3_exp", outPC, 32'hC);
      async_reset("mid");

      // Stall ignores jump; branch overrides stall.
      for (int i = 0; i < 4; i++) step("to10");
      check("at10", outPC, 32'h10);
      for (int i = 0; i < 2; i++) begin
         holdPC = 1'b1; jump = 1'b1; jump_target = 32'h200;
         step("hold_jump");
         check("hold_exp", outPC, 32'h10);
      end
      holdPC = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      step("hold_br");
      check("hold_br_exp", outPC, 32'h40);

      // Single call/return pair.
      branch_to(32'h24);
      call = 1'b1; jump_target = 32'h300;
      step("call1");
      check("call1_exp", outPC, 32'h300);
      check("call1_nempty", 32'(ras_empty), 32'h0);
      ret = 1'b1; jump_target = 32'h9990000;
      step("ret1");
      check("ret1_exp", outPC, 32'h24);
      check("ret1_empty", 32'(ras_empty), 32'h1);

      // Overflow wraps the oldest entry; underflow falls back to jump_target.
      async_reset("ovf");
      step("ovf_seq");
      for (int i = 0; i < 5; i++) begin
         call = 1'b1; jump_target = m_pc + 32'd4;
         step("ovf_call");
      end
      check("ovf_full", 32'(ras_full), 32'h1);
      for (int i = 0; i < 4; i++) begin
         ret = 1'b1; jump_target = 32'h500;
         step("ovf_ret");
         check("ovf_ret_exp", outPC, 32'h14 - 32'(4 * i));
      end
      ret = 1'b1; jump_target = 32'h500;
      step("unf_ret");
      check("unf_ret_exp", outPC, 32'h500);
      check("unf_empty", 32'(ras_empty), 32'h1);

      // Exception beats branch and call, captures EPC and clears the stack.
      branch_to(32'h800);
      call = 1'b1; jump_target = 32'h808;
      step("pre_exc_call");
      step("pre_exc_seq");
      exception = 1'b1; branch_taken = 1'b1; branch_target = 32'h1234;
      call = 1'b1; jump_target = 32'h777;
      step("exc");
      check("exc_pc", outPC, 32'h80);
      check("exc_epc", epc, 32'h80C);
      check("exc_empty", 32'(ras_empty), 32'h1);

      // Address wrap, then call+ret together pops without pushing.
      branch_to(32'hFFFF_FFFC);
      step("wrap");
      check("wrap_exp", outPC, 32'h0);
      call = 1'b1; jump_target = 32'h100; step("cr_call1");
      call = 1'b1; jump_target = 32'h200; step("cr_call2");
      call = 1'b1; ret = 1'b1; jump_target = 32'h300;
      step("cr_both");
      check("cr_both_exp", outPC, 32'h100);
      ret = 1'b1; step("cr_ret");
      check("cr_ret_exp", outPC, 32'h0);
      check("cr_empty", 32'(ras_empty), 32'h1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r == 0) begin
            async_reset("rnd_rst");
         end else begin
            exception     = ($urandom_range(0, 39) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = $urandom() & 32'hFFFF_FFFC;
            holdPC        = ($urandom_range(0, 5) == 0);
            ret           = ($urandom_range(0, 4) == 0);
            call          = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            jump_target   = $urandom() & 32'hFFFF_FFFC;
            if (r > 97) jump_target = 32'hFFFF_FFFC;
            step("rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS core. It is the next generation of the basic hold-capable PC register.
- Adds an internal incrementer, prioritised redirects (exception, EX-stage branch, ID-stage jump/call/return), exception PC capture and a circular return-address stack (RAS).
- Sits at the head of IF: outPC drives instruction memory; the hazard unit drives holdPC; EX and ID drive the redirects.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_VEC, 32'h00000000, outPC value while Reset is high and immediately after it.
- EXC_VEC, 32'h00000080, exception handler address.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- holdPC  in  1  stall from hazard detection unit.
- branch_taken  in  1  EX-stage branch resolved taken (flush redirect).
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  ID-stage unconditional jump.
- call  in  1  ID-stage call (jump and push).
- ret  in  1  ID-stage return (jump and pop).
- jump_target  in  ADDR_W  jump/call destination; also the return fallback when the RAS is empty.
- exception  in  1  trap request.
- outPC  out  ADDR_W  current fetch address.
- epc  out  ADDR_W  outPC captured at the last exception.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (asynchronous, asserted at any time, including mid-redirect):
  - outPC = RESET_VEC, epc = 0.
  - RAS count = 0 and top pointer = 0, so ras_empty = 1 and ras_full = 0.
  - The held state persists while Reset is high; the first edge after release applies normal rules.
- Every state change occurs on the rising clk edge. Next-PC is registered with one-cycle latency: a request sampled at edge N appears on outPC after edge N.
- Next-PC priority, highest first:
  1. exception: outPC <- EXC_VEC; epc <- outPC; RAS cleared (count 0). Ignores holdPC and all other requests.
  2. branch_taken: outPC <- branch_target. Overrides holdPC. RAS untouched; ID requests on the same cycle are discarded because they are wrong-path.
  3. holdPC: outPC, epc and RAS unchanged. jump/call/ret are ignored; decode re-presents them after the stall.
  4. ret:
     - RAS not empty: outPC <- top entry; pop (count-1, pointer-1 mod depth).
     - RAS empty: outPC <- jump_target; no pop, no underflow.
     - ret wins over call when both are asserted; call is then ignored.
  5. call: outPC <- jump_target; push the current outPC (already the sequential successor) as the return address.
     - When full, the oldest entry is overwritten (circular); count saturates at RAS_DEPTH.
  6. jump: outPC <- jump_target.
  7. Otherwise: outPC <- outPC + INC, wrapping modulo 2^ADDR_W (e.g. all-ones minus 3 goes to 0).
- ras_empty and ras_full are combinational from the registered count.
- epc changes only on exception.

Decomposition:
- Package pc_pkg:
  - Default constants RESET_VEC, EXC_VEC, INC.
  - Enum for the selected next-PC source (EXC, BR, HOLD, RET, CALL, JMP, SEQ) for debug visibility.
- Sub-module return_addr_stack:
  - Parameters DEPTH and W.
  - Ports clk, Reset, push, pop, clear, din, top, empty, full.
  - Circular storage, pointer and saturating count.
- pc_unit contains only the priority mux, PC register and epc register.

Test Plan:
- Reset release with no requests, 3 edges -> outPC 0x0, 0x4, 0x8, 0xC. Assert Reset mid-cycle at 0xC -> outPC reads 0x0 immediately, without waiting for clk.
- holdPC=1 for 2 cycles at 0x10 with jump=1, jump_target=0x200 -> outPC stays 0x10. Then holdPC=1 with branch_taken=1, target 0x40 -> outPC = 0x40 after one edge.
- call at outPC=0x24 with jump_target=0x300 -> outPC=0x300 and ras_empty=0. Later ret -> outPC=0x24 and ras_empty=1.
- 5 calls at outPC 0x4, 0x8, 0xC, 0x10, 0x14 with RAS_DEPTH=4 -> ras_full=1. Then 4 rets -> 0x14, 0x10, 0xC, 0x8. A 5th ret with jump_target=0x500 -> 0x500, stack stays empty.
- exception together with branch_taken and call at outPC=0x80C -> outPC=0x80, epc=0x80C, RAS cleared.
- outPC=0xFFFFFFFC sequential -> 0x00000000. Simultaneous call and ret with a non-empty RAS -> pop only, no push.
